// File: rtl/pc_redirect_ctrl.sv
// Purpose: fetch-PC sequencer handling branch/jump redirects, IF/ID squash and misaligned-target halt.
// Latency: redirect target appears on pc one edge after the redirect; flush follows the same edge.
// Backpressure: stall holds the PC in RUN/FLUSH (a redirect overrides it); HALT ignores stall until resume.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall                 hazard hold, PC does not advance while high
//   br_valid/br_taken     branch in EX and its resolved outcome
//   jump                  unconditional jump, treated as taken
//   br_target             redirect target address
//   resume/resume_pc      one-cycle release from HALT and the PC to restart at
//   pc/pc_valid           registered fetch PC and its legality
//   flush                 squash IF/ID
//   misalign_exc/exc_addr misaligned-target exception level and captured target
//   redirect_cnt          saturating count of accepted redirects
module pc_redirect_ctrl #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_PC     = 32'h0000_0000,
  parameter int               FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic            jump,
  input  logic [XLEN-1:0] br_target,
  input  logic            resume,
  input  logic [XLEN-1:0] resume_pc,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            misalign_exc,
  output logic [XLEN-1:0] exc_addr,
  output logic [15:0]     redirect_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = FLUSH_CYCLES[2:0];

  state_t     state, state_n;
  logic [2:0] flush_cnt;
  logic       redirect;
  logic       target_misaligned;

  assign redirect          = br_valid & (br_taken | jump);
  assign target_misaligned = |br_target[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      RUN: begin
        if (redirect) begin
          state_n = target_misaligned ? HALT : FLUSH;
        end
      end
      FLUSH: begin
        // Leave on the edge where the counter steps 1 -> 0.
        if (!stall && flush_cnt == 3'd1) begin
          state_n = RUN;
        end
      end
      HALT: begin
        if (resume) begin
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    flush        = 1'b0;
    pc_valid     = 1'b1;
    misalign_exc = 1'b0;
    unique case (state)
      RUN: ;
      FLUSH: flush = 1'b1;
      HALT: begin
        flush        = 1'b1;
        pc_valid     = 1'b0;
        misalign_exc = 1'b1;
      end
      default: ;
    endcase
  end

  // PC, flush counter, exception capture and redirect counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      flush_cnt    <= 3'd0;
      exc_addr     <= '0;
      redirect_cnt <= 16'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (redirect && !target_misaligned) begin
            // Accepted redirect wins over stall.
            pc        <= br_target;
            flush_cnt <= FLUSH_LOAD;
            if (redirect_cnt != 16'hFFFF) begin
              redirect_cnt <= redirect_cnt + 16'd1;
            end
          end else if (redirect) begin
            exc_addr <= br_target;
          end else if (!stall) begin
            pc <= pc + XLEN'(4);
          end
        end
        FLUSH: begin
          // Redirects here come from squashed instructions and are dropped.
          if (!stall) begin
            pc        <= pc + XLEN'(4);
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        HALT: begin
          if (resume) begin
            pc <= resume_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Purpose: directed self-checking bench for pc_redirect_ctrl with an expectation queue.
// Latency: each expectation is popped one cycle after its stimulus, #1 past the rising edge.
// Backpressure: stall is driven directly as stimulus; no handshake with the bench.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_valid, br_taken, jump, resume;
  logic [31:0] br_target, resume_pc;

  logic [31:0] pc, exc_addr;
  logic        pc_valid, flush, misalign_exc;
  logic [15:0] redirect_cnt;

  logic [31:0] pc1, exc_addr1;
  logic        pc_valid1, flush1, misalign_exc1;
  logic [15:0] redirect_cnt1;

  always #5 clk = ~clk;

  pc_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
    .jump(jump), .br_target(br_target), .resume(resume), .resume_pc(resume_pc),
    .pc(pc), .pc_valid(pc_valid), .flush(flush), .misalign_exc(misalign_exc),
    .exc_addr(exc_addr), .redirect_cnt(redirect_cnt)
  );

  pc_redirect_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
    .jump(jump), .br_target(br_target), .resume(resume), .resume_pc(resume_pc),
    .pc(pc1), .pc_valid(pc_valid1), .flush(flush1), .misalign_exc(misalign_exc1),
    .exc_addr(exc_addr1), .redirect_cnt(redirect_cnt1)
  );

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        pv;
    logic        me;
    logic [31:0] ea;
    logic [15:0] rc;
    bit          chk_hi;
    logic [31:0] pc_hi;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] p, input logic fl, input logic pv,
                      input logic me, input logic [31:0] ea, input logic [15:0] rc,
                      input bit chk_hi, input logic [31:0] p_hi);
    exp_t e;
    e.pc = p; e.fl = fl; e.pv = pv; e.me = me; e.ea = ea; e.rc = rc;
    e.chk_hi = chk_hi; e.pc_hi = p_hi;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_now();
    exp_t  e;
    string t;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp({t, ".pc"},           pc,                e.pc);
    cmp({t, ".flush"},        32'(flush),        32'(e.fl));
    cmp({t, ".pc_valid"},     32'(pc_valid),     32'(e.pv));
    cmp({t, ".misalign_exc"}, 32'(misalign_exc), 32'(e.me));
    cmp({t, ".exc_addr"},     exc_addr,          e.ea);
    cmp({t, ".redirect_cnt"}, 32'(redirect_cnt), 32'(e.rc));
    if (e.chk_hi) cmp({t, ".pc_hi"}, pc1, e.pc_hi);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic drive(input logic s, input logic bv, input logic bt, input logic j,
                       input logic [31:0] tgt);
    stall = s; br_valid = bv; br_taken = bt; jump = j; br_target = tgt;
  endtask

  initial begin
    rst_n = 1'b1;
    resume = 1'b0; resume_pc = 32'h0;
    drive(0, 0, 0, 0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    push("reset_async", 32'h0, 0, 1, 0, 32'h0, 16'd0, 1, 32'hFFFF_FFFC);
    check_now();

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push("post_release", 32'h0, 0, 1, 0, 32'h0, 16'd0, 1, 32'hFFFF_FFFC);
    check_now();

    // Sequential fetch, and wrap of the high-reset instance.
    push("seq_4", 32'h4, 0, 1, 0, 32'h0, 16'd0, 1, 32'h0); tick();
    push("seq_8", 32'h8, 0, 1, 0, 32'h0, 16'd0, 1, 32'h4); tick();
    push("seq_c", 32'hC, 0, 1, 0, 32'h0, 16'd0, 1, 32'h8); tick();
    push("seq_10", 32'h10, 0, 1, 0, 32'h0, 16'd0, 0, 32'h0); tick();

    // Taken branch while stalled: redirect still wins.
    drive(1, 1, 1, 0, 32'h100);
    push("redir_100", 32'h100, 1, 1, 0, 32'h0, 16'd1, 0, 32'h0); tick();

    // Redirect presented during FLUSH is dropped.
    drive(0, 1, 1, 0, 32'h200);
    push("flush_104", 32'h104, 1, 1, 0, 32'h0, 16'd1, 0, 32'h0); tick();
    push("flush_end_108", 32'h108, 0, 1, 0, 32'h0, 16'd1, 0, 32'h0); tick();

    // Stall holds the PC in RUN.
    drive(1, 0, 0, 0, 32'h0);
    push("stall_hold", 32'h108, 0, 1, 0, 32'h0, 16'd1, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 32'h0);
    push("unstall_10c", 32'h10C, 0, 1, 0, 32'h0, 16'd1, 0, 32'h0); tick();

    // Misaligned jump target halts.
    drive(0, 1, 0, 1, 32'h102);
    push("halt_enter", 32'h10C, 1, 0, 1, 32'h102, 16'd1, 0, 32'h0); tick();
    drive(0, 1, 1, 0, 32'h300);
    push("halt_ignore_redir", 32'h10C, 1, 0, 1, 32'h102, 16'd1, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 32'h0);
    resume = 1'b1; resume_pc = 32'h80;
    push("resume_80", 32'h80, 0, 1, 0, 32'h102, 16'd1, 0, 32'h0); tick();

    // Resume outside HALT does nothing.
    resume = 1'b1; resume_pc = 32'h40;
    push("resume_in_run", 32'h84, 0, 1, 0, 32'h102, 16'd1, 0, 32'h0); tick();
    resume = 1'b0;

    // Not-taken branch just advances.
    drive(0, 1, 0, 0, 32'h500);
    push("not_taken", 32'h88, 0, 1, 0, 32'h102, 16'd1, 0, 32'h0); tick();

    // Jump with br_taken low still redirects; stall in FLUSH freezes counter.
    drive(0, 1, 0, 1, 32'h400);
    push("jump_400", 32'h400, 1, 1, 0, 32'h102, 16'd2, 0, 32'h0); tick();
    drive(1, 0, 0, 0, 32'h0);
    push("flush_stall", 32'h400, 1, 1, 0, 32'h102, 16'd2, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 32'h0);
    push("flush_404", 32'h404, 1, 1, 0, 32'h102, 16'd2, 0, 32'h0); tick();
    push("flush_done_408", 32'h408, 0, 1, 0, 32'h102, 16'd2, 0, 32'h0); tick();

    // Async reset mid-FLUSH.
    drive(0, 1, 1, 0, 32'h500);
    push("redir_500", 32'h500, 1, 1, 0, 32'h102, 16'd3, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    push("reset_mid_flush", 32'h0, 0, 1, 0, 32'h0, 16'd0, 1, 32'hFFFF_FFFC);
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    push("run_after_reset", 32'h4, 0, 1, 0, 32'h0, 16'd0, 1, 32'h0); tick();

    // Reset taken while halted.
    drive(0, 1, 1, 0, 32'h7);
    push("halt_again", 32'h4, 1, 0, 1, 32'h7, 16'd0, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push("reset_in_halt", 32'h0, 0, 1, 0, 32'h0, 16'd0, 0, 32'h0);
    check_now();
    #2 rst_n = 1'b1;
    push("run_after_halt_reset", 32'h4, 0, 1, 0, 32'h0, 16'd0, 0, 32'h0); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-003 Parameter FLUSH_CYCLES, default 2, range 1..7, number of squash cycles after a redirect.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 stall  in  1  hazard hold; PC shall not advance when high.
REQ-007 br_valid  in  1  branch/jump instruction present in EX this cycle.
REQ-008 br_taken  in  1  conditional branch outcome from the branch-select stage.
REQ-009 jump  in  1  unconditional jump (JAL/JALR); qualifies as taken.
REQ-010 br_target  in  XLEN  redirect target address.
REQ-011 resume  in  1  one-cycle pulse releasing HALT.
REQ-012 resume_pc  in  XLEN  PC loaded on resume (trap vector).
REQ-013 pc  out  XLEN  registered fetch PC.
REQ-014 pc_valid  out  1  PC is a legal fetch address (low only in HALT).
REQ-015 flush  out  1  squash IF/ID stages.
REQ-016 misalign_exc  out  1  instruction-address-misaligned exception, level, held in HALT.
REQ-017 exc_addr  out  XLEN  offending target captured at exception.
REQ-018 redirect_cnt  out  16  count of accepted redirects, saturating.

Function
REQ-019 States RUN, FLUSH, HALT; redirect = br_valid & (br_taken | jump).
REQ-020 RUN, no redirect: pc <= pc + 4 when stall=0, pc held when stall=1.
REQ-021 RUN, redirect with br_target[1:0]==0: pc <= br_target next edge regardless of stall; load flush counter with FLUSH_CYCLES; go to FLUSH; redirect_cnt increments.
REQ-022 RUN, redirect with br_target[1:0]!=0: pc held; exc_addr <= br_target; go to HALT; redirect_cnt unchanged.
REQ-023 FLUSH: flush=1 in every FLUSH cycle; flush asserted starting the cycle after the redirect edge.
REQ-024 FLUSH: counter decrements only on cycles with stall=0; return to RUN on the edge where counter goes 1->0.
REQ-025 FLUSH: pc advances by 4 when stall=0, as in RUN.
REQ-026 FLUSH: redirect inputs ignored (squashed instructions); no count, no exception.
REQ-027 HALT: pc frozen, pc_valid=0, misalign_exc=1, flush=1, stall ignored.
REQ-028 HALT with resume=1: pc <= resume_pc, misalign_exc clears, go to RUN next edge.
REQ-029 resume outside HALT shall have no effect.
REQ-030 pc + 4 wraps modulo 2^XLEN (max-aligned PC -> 0), no flag.
REQ-031 redirect_cnt saturates at 16'hFFFF.
REQ-032 flush, pc_valid, misalign_exc decoded from registered state only (no input-to-output combinational paths).

Reset
REQ-033 rst_n low forces, immediately and regardless of clk: state RUN, pc=RESET_PC, pc_valid=1, flush=0, misalign_exc=0, exc_addr=0, redirect_cnt=0, flush counter=0.
REQ-034 Reset asserted mid-FLUSH or in HALT abandons the operation; first edge after deassert behaves as RUN.

Verification
REQ-035 Reset release, stall=0 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; flush=0.
REQ-036 At pc=0x10, br_valid=1, br_taken=1, br_target=0x100 with stall=1 -> next pc=0x100, flush=1 for exactly 2 cycles, redirect_cnt=1.
REQ-037 In FLUSH, second redirect to 0x200 presented -> ignored, pc continues 0x104, 0x108; redirect_cnt stays 1.
REQ-038 jump=1, br_target=0x102 -> HALT: pc_valid=0, misalign_exc=1, exc_addr=0x102, pc frozen; resume with resume_pc=0x80 -> pc=0x80, RUN, misalign_exc=0.
REQ-039 RESET_PC=0xFFFF_FFFC, stall=0 -> pc 0xFFFF_FFFC then 0x0000_0000.
REQ-040 rst_n pulsed low between clock edges during FLUSH -> outputs return to reset values asynchronously, flush=0 before next edge.
